// File: rtl/parity_pkg.sv
// Shared definitions for both ends of the parity link: FSM states, default widths
// and the single parity function that generator and checker both call.
package parity_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Callers zero-extend narrower words; the padding zeros leave the XOR unchanged.
    function automatic logic parity_of(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Bundles the serial input, its control strobes and the result outputs of the
// frame checker. The checker connects through the slave modport.
interface parity_frame_checker_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              sin;
    logic              sin_valid;
    logic              abort;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              busy;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output sin, sin_valid, abort, err_clr,
        input  data_out, data_valid, parity_err, busy, err_count
    );

    modport slave (
        input  sin, sin_valid, abort, err_clr,
        output data_out, data_valid, parity_err, busy, err_count
    );
endinterface

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear and an increment in the
// same cycle load the value 1, so the event that coincides with the clear is kept.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/parity_frame_checker.sv
// Receive-side checker: shifts in {parity, data MSB-first} and reports the data with
// a parity verdict. The error counter is built only when PARITY_ERR_CNT_EN is defined.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    parity_frame_checker_if.slave   bus
);
    localparam int   BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic ODD  = (ODD_PARITY != 0);

    state_t            state_q, state_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] shift_next;

    assign shift_next = (shift_q << 1) | DATA_W'(bus.sin);

    // Abort is checked first in each state so it always wins over a coincident bit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        perr_d    = perr_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (!bus.abort && bus.sin_valid) begin
                    par_d   = bus.sin;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (bus.sin_valid) begin
                    shift_d = shift_next;
                    if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        data_d    = shift_next;
                        perr_d    = par_q != parity_of(32'(shift_next), ODD);
                        valid_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.parity_err = perr_q;
    assign bus.data_valid = valid_q;
    assign bus.busy       = (state_q == RECV);

`ifdef PARITY_ERR_CNT_EN
    // Driven from next-state so the count changes together with data_valid.
    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (valid_d & perr_d),
        .clr   (bus.err_clr),
        .count (bus.err_count)
    );
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.err_count  = '0;
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomised and directed bench for parity_frame_checker, running an even- and an
// odd-parity instance side by side against a frame-level reference model.
module tb_parity_frame_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    parity_frame_checker_if #(.DATA_W(4), .CNT_W(8)) ife ();
    parity_frame_checker_if #(.DATA_W(4), .CNT_W(8)) ifo ();

    assign ifo.sin       = ife.sin;
    assign ifo.sin_valid = ife.sin_valid;
    assign ifo.abort     = ife.abort;
    assign ifo.err_clr   = ife.err_clr;

    parity_frame_checker #(.DATA_W(4), .ODD_PARITY(0), .CNT_W(8)) dutEven (
        .clk (clk),
        .rst (rst),
        .bus (ife)
    );

    parity_frame_checker #(.DATA_W(4), .ODD_PARITY(1), .CNT_W(8)) dutOdd (
        .clk (clk),
        .rst (rst),
        .bus (ifo)
    );

    // Reference model: bits of the frame in progress, plus the expected visible outputs.
    logic       frameBits[$];
    logic [3:0] expData   = '0;
    logic       expPerrE  = 1'b0;
    logic       expPerrO  = 1'b0;
    logic       expValid  = 1'b0;
    logic       expBusy   = 1'b0;
    int         expCntE   = 0;
    int         expCntO   = 0;

    function automatic int nextCount(input int cnt, input logic bad, input logic clr);
        if (clr) return bad ? 1 : 0;
        if (bad) return (cnt < 255) ? cnt + 1 : 255;
        return cnt;
    endfunction

    task automatic modelEdge(input logic s, input logic v, input logic a, input logic c, input logic r);
        int   ones;
        logic badE;
        logic badO;
        badE = 1'b0;
        badO = 1'b0;
        if (r) begin
            frameBits.delete();
            expData  = '0;
            expPerrE = 1'b0;
            expPerrO = 1'b0;
            expValid = 1'b0;
            expCntE  = 0;
            expCntO  = 0;
        end else begin
            expValid = 1'b0;
            if (a) begin
                frameBits.delete();
            end else if (v) begin
                frameBits.push_back(s);
                if (frameBits.size() == 5) begin
                    ones = 0;
                    for (int i = 1; i <= 4; i++) begin
                        expData[4-i] = frameBits[i];
                        ones += int'(frameBits[i]);
                    end
                    expPerrE = (int'(frameBits[0]) != (ones % 2));
                    expPerrO = (int'(frameBits[0]) != ((ones + 1) % 2));
                    expValid = 1'b1;
                    badE     = expPerrE;
                    badO     = expPerrO;
                    frameBits.delete();
                end
            end
`ifdef PARITY_ERR_CNT_EN
            expCntE = nextCount(expCntE, badE, c);
            expCntO = nextCount(expCntO, badO, c);
`else
            expCntE = 0;
            expCntO = 0;
`endif
        end
        expBusy = (frameBits.size() != 0);
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
            $error("[TB] %s wrong", tag);
        end
    endtask

    task automatic checkAll();
        checkOutput("validE", int'(ife.data_valid), int'(expValid));
        checkOutput("validO", int'(ifo.data_valid), int'(expValid));
        checkOutput("busyE",  int'(ife.busy),       int'(expBusy));
        checkOutput("busyO",  int'(ifo.busy),       int'(expBusy));
        checkOutput("dataE",  int'(ife.data_out),   int'(expData));
        checkOutput("dataO",  int'(ifo.data_out),   int'(expData));
        checkOutput("perrE",  int'(ife.parity_err), int'(expPerrE));
        checkOutput("perrO",  int'(ifo.parity_err), int'(expPerrO));
        checkOutput("cntE",   int'(ife.err_count),  expCntE);
        checkOutput("cntO",   int'(ifo.err_count),  expCntO);
    endtask

    // One clock: drive inputs, let the edge happen, update the model, then compare.
    task automatic applyStimulus(input logic s, input logic v, input logic a, input logic c, input logic r);
        ife.sin       = s;
        ife.sin_valid = v;
        ife.abort     = a;
        ife.err_clr   = c;
        rst           = r;
        @(posedge clk);
        modelEdge(s, v, a, c, r);
        #1;
        checkAll();
    endtask

    task automatic idleCycle();
        applyStimulus(1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Frame vector is {parity, data[3:0]}; bit 4 is sent first.
    task automatic sendFrame(input logic [4:0] frame, input int gapMax, input logic clrLast);
        int gaps;
        for (int i = 4; i >= 0; i--) begin
            gaps = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
            repeat (gaps) idleCycle();
            applyStimulus(frame[i], 1'b1, 1'b0, (i == 0) ? clrLast : 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [4:0] rf;
        ife.sin = 1'b0; ife.sin_valid = 1'b0; ife.abort = 1'b0; ife.err_clr = 1'b0;
        $display("[TB] start");

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idleCycle();

        sendFrame(5'b00011, 0, 1'b0);
        repeat (2) idleCycle();
        sendFrame(5'b11011, 1, 1'b0);
        sendFrame(5'b00111, 1, 1'b0);
        repeat (2) idleCycle();

        sendFrame(5'b00000, 0, 1'b0);
        sendFrame(5'b01111, 0, 1'b0);
        repeat (3) idleCycle();

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) idleCycle();
        sendFrame(5'b00011, 0, 1'b0);
        idleCycle();

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sendFrame(5'b00011, 0, 1'b0);
        idleCycle();

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        sendFrame(5'b10011, 0, 1'b0);
        sendFrame(5'b00011, 2, 1'b0);
        idleCycle();

        for (int f = 0; f < 60; f++) begin
            rf = 5'($urandom);
            if ($urandom_range(9, 0) == 0) begin
                applyStimulus(rf[4], 1'b1, 1'b0, 1'b0, 1'b0);
                applyStimulus(rf[3], 1'b1, 1'b0, 1'b0, 1'b0);
                applyStimulus(rf[2], 1'($urandom), 1'b1, 1'b0, 1'b0);
            end
            sendFrame(rf, 2, ($urandom_range(4, 0) == 0));
            if ($urandom_range(7, 0) == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        idleCycle();

        for (int f = 0; f < 262; f++) sendFrame(5'b10000, 0, 1'b0);
        idleCycle();
        sendFrame(5'b10000, 0, 1'b1);
        idleCycle();
        sendFrame(5'b11000, 1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
